// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD job sequencer: default operand width and FSM encoding.
package gcd_pkg;

    localparam int unsigned GCD_WIDTH = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_LOAD   = 3'd2,
        S_RUN    = 3'd3,
        S_DONE   = 3'd4
    } seq_state_e;

endpackage

// File: rtl/gcd_op_fifo.sv
// Synchronous operand-pair FIFO; head entry is visible combinationally on rdata_c.
module gcd_op_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rdata_c,
    output logic              full_c,
    output logic              empty_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned AW    = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign full_c  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign rdata_c = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (push_i && !full_c) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_c) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_i && !empty_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

endmodule

// File: rtl/gcd_job_sequencer.sv
// Buffers operand pairs, launches one GCD core job at a time, resolves zero operands
// locally and recovers a hung core with a RUN-state watchdog.
module gcd_job_sequencer
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH      = GCD_WIDTH,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned MAX_CYCLES = 65540
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             go,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             core_rst,
    input  logic             a_eq_b,
    input  logic [WIDTH-1:0] gcd_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic             out_bypass,
    output logic             out_timeout
);

    localparam int unsigned CNT_W = $clog2(MAX_CYCLES + 1);

    seq_state_e         state_q;
    logic [CNT_W-1:0]   wd_cnt_q;
    logic               wd_pulse_q;
    logic               go_q;
    logic [WIDTH-1:0]   op_a_q;
    logic [WIDTH-1:0]   op_b_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   out_gcd_q;
    logic               out_bypass_q;
    logic               out_timeout_q;

    logic [2*WIDTH-1:0] fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               out_free;
    logic [WIDTH-1:0]   head_a;
    logic [WIDTH-1:0]   head_b;

    assign in_ready = !rst && !fifo_full;
    assign push     = in_valid && in_ready;
    assign out_free = !out_valid_q || out_ready;
    assign pop      = (state_q == S_IDLE) && !fifo_empty && out_free;
    assign head_a   = fifo_rdata[2*WIDTH-1:WIDTH];
    assign head_b   = fifo_rdata[WIDTH-1:0];

    gcd_op_fifo #(
        .DATA_W (2 * WIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i ({in_a, in_b}),
        .pop_i   (pop),
        .rdata_c (fifo_rdata),
        .full_c  (fifo_full),
        .empty_c (fifo_empty)
    );

    // Job FSM, watchdog and output register share one register process.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wd_cnt_q      <= '0;
            wd_pulse_q    <= 1'b0;
            go_q          <= 1'b0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            out_valid_q   <= 1'b0;
            out_gcd_q     <= '0;
            out_bypass_q  <= 1'b0;
            out_timeout_q <= 1'b0;
        end else begin
            go_q       <= 1'b0;
            wd_pulse_q <= 1'b0;
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        op_a_q <= head_a;
                        op_b_q <= head_b;
                        // A zero operand would never converge by subtraction.
                        if ((head_a == '0) || (head_b == '0)) begin
                            out_valid_q   <= 1'b1;
                            out_gcd_q     <= (head_a == '0) ? head_b : head_a;
                            out_bypass_q  <= 1'b1;
                            out_timeout_q <= 1'b0;
                        end else begin
                            go_q    <= 1'b1;
                            state_q <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: state_q <= S_LOAD;
                S_LOAD: begin
                    wd_cnt_q <= '0;
                    state_q  <= S_RUN;
                end
                S_RUN: begin
                    if (a_eq_b) begin
                        out_valid_q   <= 1'b1;
                        out_gcd_q     <= gcd_val;
                        out_bypass_q  <= 1'b0;
                        out_timeout_q <= 1'b0;
                        state_q       <= S_DONE;
                    end else if (wd_cnt_q == CNT_W'(MAX_CYCLES - 1)) begin
                        out_valid_q   <= 1'b1;
                        out_gcd_q     <= '0;
                        out_bypass_q  <= 1'b0;
                        out_timeout_q <= 1'b1;
                        wd_pulse_q    <= 1'b1;
                        state_q       <= S_DONE;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + CNT_W'(1);
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign go          = go_q;
    assign op_a        = op_a_q;
    assign op_b        = op_b_q;
    assign core_rst    = rst || wd_pulse_q;
    assign out_valid   = out_valid_q;
    assign out_gcd     = out_gcd_q;
    assign out_bypass  = out_bypass_q;
    assign out_timeout = out_timeout_q;

endmodule
